bin2bcd_seq: RTL
================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL provide parameter IN_W, default 14: binary input width, legal range 1..32.
REQ-002 SHALL provide parameter DIGITS, default 4: number of BCD output digits, legal range 1..10.
REQ-003 SHALL provide port clk, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-004 SHALL provide port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL provide port start, input, 1 bit: conversion request, sampled on the rising edge of clk.
REQ-006 SHALL provide port in, input, IN_W bits: unsigned binary operand, sampled only when start is accepted.
REQ-007 SHALL provide port busy, output, 1 bit: high while a conversion is in progress.
REQ-008 SHALL provide port done, output, 1 bit: one-cycle pulse when new results are valid.
REQ-009 SHALL provide port bcd, output, 4*DIGITS bits: packed digits, least-significant digit in bits [3:0].
REQ-010 SHALL provide port overflow, output, 1 bit: high when the last operand was >= 10^DIGITS.

Function
REQ-011 SHALL implement the states IDLE and SHIFT.
REQ-012 SHALL accept start only in IDLE; on acceptance it latches in into the low IN_W bits of an IN_W+4*DIGITS shift register, clears the digit field, loads a cycle counter with IN_W, and enters SHIFT.
REQ-013 SHALL, in each SHIFT cycle, add 3 to every digit >= 5 and then shift the whole register left by one bit, both in the same cycle, and decrement the counter.
REQ-014 SHALL set a sticky overflow flag in any SHIFT cycle in which a 1 is shifted out of the top digit or the top digit's adjusted value is >= 10.
REQ-015 SHALL, in the SHIFT cycle where the counter equals 1, register the final digits to bcd, pulse done high for exactly the next cycle, update overflow, and return to IDLE.
REQ-016 SHALL keep latency fixed at IN_W cycles: done is high in the cycle beginning IN_W rising edges after the edge that accepted start.
REQ-017 SHALL hold busy high from the accepting edge until the edge that raises done, and hold it low otherwise.
REQ-018 SHALL ignore start while busy, and SHALL accept start in the cycle in which done is high (back-to-back operation).
REQ-019 SHALL saturate bcd to all digits 9 when overflow is set.
REQ-020 SHALL hold bcd and overflow stable between done pulses.
REQ-021 SHALL return IN_W-bit zero as bcd all zeros with overflow 0.

Reset
REQ-022 SHALL, on reset assertion, immediately force state to IDLE, busy=0, done=0, overflow=0, bcd=0, and clear the shift register and counter.
REQ-023 SHALL, when reset is asserted mid-conversion, abort the conversion with no done pulse; the first start after reset deasserts begins a fresh conversion.

Configuration
REQ-024 SHALL, when BIN2BCD_BLANK_EN is defined, replace leading zero digits in bcd with 4'hF (blank code), always leaving digit 0 numeric; overflow saturation is never blanked.
REQ-025 SHALL, when BIN2BCD_BLANK_EN is undefined, output leading zeros as 4'h0 and contain no blanking logic.

Verification
REQ-026 Defaults, in=1234, start 1 cycle -> busy for 14 cycles, done at cycle 14, bcd=16'h1234, overflow=0.
REQ-027 Defaults, in=9999 then in=16383 back-to-back (start held through done) -> bcd=16'h9999 with overflow=0, then bcd=16'h9999 with overflow=1.
REQ-028 Defaults, start at 5678, start pulsed again at cycle 5 with in=1 -> single done, bcd=16'h5678, second start ignored.
REQ-029 Defaults, reset asserted at cycle 7 of a 4321 conversion -> outputs zero at once, no done; next start of 4321 -> bcd=16'h4321.
REQ-030 IN_W=8, DIGITS=3, in=255 -> done after 8 cycles, bcd=12'h255; in=0 -> 12'h000.
REQ-031 BIN2BCD_BLANK_EN defined, defaults, in=42 -> bcd=16'hFF42; in=0 -> bcd=16'hFFF0.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3), one input bit per cycle.
// Latency: done pulses IN_W cycles after the accepting edge; a new start is accepted in the done cycle.
// Backpressure: start is ignored while busy; results hold stable until the next done pulse.
//
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous, active-high reset
//   start    - conversion request, accepted only when idle
//   in       - IN_W-bit unsigned operand, captured on acceptance
//   busy     - high while a conversion is in progress
//   done     - one-cycle pulse when bcd/overflow carry a new result
//   bcd      - DIGITS packed BCD digits, digit 0 in bits [3:0]
//   overflow - operand did not fit in DIGITS digits (bcd then saturates to all 9s)
//
// Optional build macro: BIN2BCD_BLANK_EN -- leading zero digits are shown as 4'hF
// (digit 0 always numeric, saturated results never blanked).

module bin2bcd_seq #(
  parameter int IN_W   = 14,
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [IN_W-1:0]     in,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = IN_W + BCD_W;
  localparam int CNT_W = $clog2(IN_W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_nxt;
  logic [SR_W-1:0]   sr, sr_nxt;
  logic [SR_W-1:0]   sr_adj;
  logic [SR_W-1:0]   sr_shift;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              ovf_sticky, ovf_sticky_nxt;
  logic              ovf_step;
  logic              ovf_final;
  logic              done_nxt;
  logic              overflow_nxt;
  logic [BCD_W-1:0]  bcd_nxt;
  logic [BCD_W-1:0]  digits_fin;
  logic [BCD_W-1:0]  bcd_fmt;
`ifdef BIN2BCD_BLANK_EN
  logic              lead;
`endif

  // Datapath for one iteration: add 3 to each digit >= 5, then shift left.
  // The top digit overflows if a 1 leaves the register or its adjusted value
  // is not a legal digit.
  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr[IN_W + 4*i +: 4] >= 4'd5)
        sr_adj[IN_W + 4*i +: 4] = sr[IN_W + 4*i +: 4] + 4'd3;
    end
    sr_shift   = sr_adj << 1;
    ovf_step   = sr_adj[SR_W-1] | (sr_adj[SR_W-1 -: 4] >= 4'd10);
    ovf_final  = ovf_sticky | ovf_step;
    digits_fin = sr_shift[IN_W +: BCD_W];
  end

  // Output formatting of the final digits: saturation wins over blanking.
  always_comb begin
    bcd_fmt = digits_fin;
`ifdef BIN2BCD_BLANK_EN
    lead = 1'b1;
`endif
    if (ovf_final) begin
      for (int i = 0; i < DIGITS; i++)
        bcd_fmt[4*i +: 4] = 4'd9;
    end else begin
`ifdef BIN2BCD_BLANK_EN
      // Walk down from the top digit; blank zeros until the first non-zero.
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (lead && (digits_fin[4*i +: 4] == 4'd0))
          bcd_fmt[4*i +: 4] = 4'hF;
        else
          lead = 1'b0;
      end
`endif
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_nxt      = state;
    sr_nxt         = sr;
    cnt_nxt        = cnt;
    ovf_sticky_nxt = ovf_sticky;
    done_nxt       = 1'b0;
    bcd_nxt        = bcd;
    overflow_nxt   = overflow;
    busy           = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          sr_nxt         = {{BCD_W{1'b0}}, in};
          cnt_nxt        = CNT_W'(IN_W);
          ovf_sticky_nxt = 1'b0;
          state_nxt      = SHIFT;
        end
      end
      SHIFT: begin
        busy           = 1'b1;
        sr_nxt         = sr_shift;
        cnt_nxt        = cnt - CNT_W'(1);
        ovf_sticky_nxt = ovf_final;
        if (cnt == CNT_W'(1)) begin
          done_nxt     = 1'b1;
          bcd_nxt      = bcd_fmt;
          overflow_nxt = ovf_final;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sr         <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      done       <= 1'b0;
      bcd        <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      sr         <= sr_nxt;
      cnt        <= cnt_nxt;
      ovf_sticky <= ovf_sticky_nxt;
      done       <= done_nxt;
      bcd        <= bcd_nxt;
      overflow   <= overflow_nxt;
    end
  end

endmodule
